// File: rtl/pim_ser_pkg.sv
// Shared types and default sizing for the PIM output serializer.
// Imported by the serializer top, its word mux and the stream interface users.
package pim_ser_pkg;

    localparam int PIM_DATA_W = 1024;
    localparam int PIM_WORD_W = 32;
    localparam int PIM_NWORDS = 2 * PIM_DATA_W / PIM_WORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } ser_state_e;

    function automatic int ser_idx_w(input int data_w, input int word_w);
        return $clog2(2 * data_w / word_w);
    endfunction

endpackage

// File: rtl/pim_output_serializer_if.sv
// Word stream toward the RISC-V peripheral side: word, index, valid/ready.
// master = serializer, slave = consumer.
interface pim_ser_stream_if #(
    parameter int WORD_W = pim_ser_pkg::PIM_WORD_W,
    parameter int IDX_W  = pim_ser_pkg::ser_idx_w(pim_ser_pkg::PIM_DATA_W, pim_ser_pkg::PIM_WORD_W)
);
    logic [WORD_W-1:0] word_o;
    logic              word_valid_o;
    logic              word_ready_i;
    logic [IDX_W-1:0]  word_idx_o;

    modport master (
        output word_o,
        output word_valid_o,
        output word_idx_o,
        input  word_ready_i
    );

    modport slave (
        input  word_o,
        input  word_valid_o,
        input  word_idx_o,
        output word_ready_i
    );
endinterface

// File: rtl/pim_word_mux.sv
// Combinational slice select: word idx from {shadow_2, shadow_1}, LSB slice first.
// Output is forced to zero when the stream is not valid.
module pim_word_mux
    import pim_ser_pkg::*;
#(
    parameter int DATA_W = PIM_DATA_W,
    parameter int WORD_W = PIM_WORD_W,
    parameter int NWORDS = 2 * DATA_W / WORD_W,
    parameter int IDX_W  = $clog2(NWORDS)
) (
    input  logic [DATA_W-1:0] shadow_1_i,
    input  logic [DATA_W-1:0] shadow_2_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              en_i,
    output logic [WORD_W-1:0] word_o
);
    // Concatenating shadow_2 above shadow_1 makes word k land at packed index k.
    logic [NWORDS-1:0][WORD_W-1:0] words;

    assign words  = {shadow_2_i, shadow_1_i};
    assign word_o = en_i ? words[idx_i] : '0;

endmodule

// File: rtl/pim_output_serializer.sv
// Captures two PIM result vectors on load_i and streams them as WORD_W words.
// Optional sticky overrun_o flag under PIM_SER_OVERRUN_EN.
module pim_output_serializer
    import pim_ser_pkg::*;
#(
    parameter int DATA_W = PIM_DATA_W,
    parameter int WORD_W = PIM_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] output_1_i,
    input  logic [DATA_W-1:0] output_2_i,
    input  logic              load_i,
    input  logic              abort_i,
    pim_ser_stream_if.master  sif,
    output logic              busy_o,
    output logic              done_o
`ifdef PIM_SER_OVERRUN_EN
    ,
    output logic              overrun_o
`endif
);
    localparam int NWORDS = 2 * DATA_W / WORD_W;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shadow_1_q, shadow_1_d;
    logic [DATA_W-1:0] shadow_2_q, shadow_2_d;
    logic              load_ok;
    logic              handshake;

    assign handshake = (state_q == STREAM) && sif.word_ready_i;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_1_d = shadow_1_q;
        shadow_2_d = shadow_2_q;
        load_ok    = 1'b0;
        // Abort outranks everything, including a same-cycle load or final handshake.
        if (abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_i) begin
                        load_ok    = 1'b1;
                        shadow_1_d = output_1_i;
                        shadow_2_d = output_2_i;
                        idx_d      = '0;
                        state_d    = STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shadow_1_q <= '0;
            shadow_2_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_1_q <= shadow_1_d;
            shadow_2_q <= shadow_2_d;
        end
    end

`ifdef PIM_SER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Any load not taken (busy, or dropped by abort) marks an overrun until the next accepted load.
    always_comb begin
        overrun_d = overrun_q;
        if (load_ok) begin
            overrun_d = 1'b0;
        end else if (load_i) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    logic unused_load_ok;
    assign unused_load_ok = load_ok;
`endif

    pim_word_mux #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .IDX_W  (IDX_W)
    ) u_word_mux (
        .shadow_1_i (shadow_1_q),
        .shadow_2_i (shadow_2_q),
        .idx_i      (idx_q),
        .en_i       (state_q == STREAM),
        .word_o     (sif.word_o)
    );

    assign sif.word_valid_o = (state_q == STREAM);
    assign sif.word_idx_o   = idx_q;
    assign busy_o           = (state_q == STREAM);
    assign done_o           = (state_q == DONE);

endmodule

// File: tb/tb_pim_output_serializer.sv
// Self-checking bench: cycle table for short corner cases, plus randomized transfers
// scored against a slice-order model of the two captured vectors.
module tb_pim_output_serializer;
    import pim_ser_pkg::*;

    localparam int DW   = PIM_DATA_W;
    localparam int WW   = PIM_WORD_W;
    localparam int NW   = 2 * DW / WW;
    localparam int HALF = NW / 2;
    localparam int IW   = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] out1, out2;
    logic          load, abort;
    logic          busy, done;
`ifdef PIM_SER_OVERRUN_EN
    logic          ovr;
`endif

    pim_ser_stream_if #(.WORD_W(WW), .IDX_W(IW)) sif();

    pim_output_serializer #(.DATA_W(DW), .WORD_W(WW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .output_1_i (out1),
        .output_2_i (out2),
        .load_i     (load),
        .abort_i    (abort),
        .sif        (sif),
        .busy_o     (busy),
        .done_o     (done)
`ifdef PIM_SER_OVERRUN_EN
        ,
        .overrun_o  (ovr)
`endif
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] m1, m2;
    logic [WW-1:0] obs [NW];

    typedef struct packed {
        bit         newdat;
        bit         ld;
        bit         ab;
        bit         rd;
        bit         cap;
        bit         v;
        bit         b;
        bit         d;
        logic [7:0] idx;
        bit         ov;
    } tv_t;

    tv_t tbl [15];

    function automatic logic [WW-1:0] model_word(input logic [DW-1:0] a, input logic [DW-1:0] b, input int k);
        if (k < HALF) return a[k*WW +: WW];
        return b[(k-HALF)*WW +: WW];
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DW-1:0] inc_vec(input logic [31:0] base);
        logic [DW-1:0] v;
        for (int i = 0; i < DW/WW; i++) v[i*WW +: WW] = WW'(base + 32'(i));
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ov(input string nm, input bit exp);
`ifdef PIM_SER_OVERRUN_EN
        chk(nm, 64'(ovr), 64'(exp));
`else
        if (exp === 1'bx) $display("unreachable %s", nm);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer; returns early (still streaming) when the observed index reaches cut_at.
    task automatic run_xfer(input logic [DW-1:0] a, input logic [DW-1:0] b, input int rdy_pct,
                            input int inject_at, input bit load_in_done, input int cut_at);
        int            k = 0;
        int            vcyc = 0;
        bit            rdy;
        bit            stalled = 1'b0;
        bit            injected = 1'b0;
        logic [WW-1:0] pw;
        logic [IW-1:0] pi;
        out1 = a; out2 = b; load = 1'b1; sif.word_ready_i = 1'b0;
        step();
        load = 1'b0;
        chk_ov("ov_clr_on_load", 1'b0);
        m1 = a; m2 = b;
        for (int cyc = 0; cyc < 4000 && k < NW; cyc++) begin
            if (k == cut_at) return;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            if (k == inject_at && !injected) begin
                out1 = rand_vec(); out2 = rand_vec(); load = 1'b1; injected = 1'b1;
            end else begin
                load = 1'b0;
            end
            sif.word_ready_i = rdy;
            chk("valid", 64'(sif.word_valid_o), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_early", 64'(done), 64'd0);
            chk("word", 64'(sif.word_o), 64'(model_word(m1, m2, k)));
            chk("idx", 64'(sif.word_idx_o), 64'(k));
            if (stalled) begin
                chk("stall_word", 64'(sif.word_o), 64'(pw));
                chk("stall_idx", 64'(sif.word_idx_o), 64'(pi));
            end
            pw = sif.word_o; pi = sif.word_idx_o; stalled = !rdy;
            vcyc++;
            if (rdy) begin
                obs[k] = sif.word_o;
                k++;
            end
            step();
        end
        load = 1'b0;
        if (k < NW) begin
            chk("xfer_timeout", 64'(k), 64'(NW));
            return;
        end
        if (rdy_pct >= 100) chk("valid_cycles", 64'(vcyc), 64'(NW));
        chk("done_pulse", 64'(done), 64'd1);
        chk("valid_in_done", 64'(sif.word_valid_o), 64'd0);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("word_zero_in_done", 64'(sif.word_o), 64'd0);
        if (load_in_done) begin
            out1 = rand_vec(); out2 = rand_vec(); load = 1'b1;
        end
        step();
        load = 1'b0;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_valid", 64'(sif.word_valid_o), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        if (inject_at >= 0 || load_in_done) chk_ov("ov_set", 1'b1);
    endtask

    initial begin
        logic [DW-1:0] a, b;
        rst_ni = 1'b0; load = 1'b0; abort = 1'b0; sif.word_ready_i = 1'b0;
        out1 = rand_vec(); out2 = rand_vec();
        m1 = '0; m2 = '0;

        //           new ld ab rd cap  v  b  d  idx ov
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'd0, 1'b1};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 8'd0, 1'b1};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'd0, 1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'd0, 1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'd1, 1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'd2, 1'b1};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'd2, 1'b1};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'd2, 1'b1};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 8'd0, 1'b1};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 8'd0, 1'b1};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'd0, 1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'd1, 1'b0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'd0, 1'b0};

        step(); step();
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].newdat) begin out1 = rand_vec(); out2 = rand_vec(); end
            load = tbl[i].ld; abort = tbl[i].ab; sif.word_ready_i = tbl[i].rd;
            chk($sformatf("tbl%0d_valid", i), 64'(sif.word_valid_o), 64'(tbl[i].v));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].b));
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].d));
            chk($sformatf("tbl%0d_idx", i), 64'(sif.word_idx_o), 64'(tbl[i].idx));
            chk($sformatf("tbl%0d_word", i), 64'(sif.word_o),
                tbl[i].v ? 64'(model_word(m1, m2, int'(tbl[i].idx))) : 64'd0);
            chk_ov($sformatf("tbl%0d_ov", i), tbl[i].ov);
            if (tbl[i].cap) begin m1 = out1; m2 = out2; end
            step();
        end
        load = 1'b0; abort = 1'b0;

        // Directed first transfer with marker words at both ends.
        a = rand_vec(); b = rand_vec();
        a[31:0] = 32'hA5A5_0001; b[DW-1 -: 32] = 32'hDEAD_BEEF;
        run_xfer(a, b, 100, -1, 1'b0, -1);
        chk("tp_word0", 64'(obs[0]), 64'h0000_0000_A5A5_0001);
        chk("tp_word63", 64'(obs[NW-1]), 64'h0000_0000_DEAD_BEEF);

        // Back-pressure with incrementing and random patterns.
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) run_xfer(inc_vec(32'(n) << 8), inc_vec((32'(n) << 8) + 32'(HALF)), 50, -1, 1'b0, -1);
            else            run_xfer(rand_vec(), rand_vec(), 50, -1, 1'b0, -1);
        end

        // Abort at idx 17.
        run_xfer(rand_vec(), rand_vec(), 100, -1, 1'b0, 17);
        chk("abort_pre_idx", 64'(sif.word_idx_o), 64'd17);
        abort = 1'b1; sif.word_ready_i = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 64'(sif.word_valid_o), 64'd0);
        chk("abort_idx", 64'(sif.word_idx_o), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 64'(done), 64'd0);
            step();
        end
        run_xfer(rand_vec(), rand_vec(), 100, -1, 1'b0, -1);

        // Load while streaming at idx 5 is ignored; next accepted load clears overrun.
        run_xfer(rand_vec(), rand_vec(), 100, 5, 1'b0, -1);
        run_xfer(rand_vec(), rand_vec(), 70, -1, 1'b0, -1);

        // Asynchronous reset at idx 40.
        run_xfer(rand_vec(), rand_vec(), 100, -1, 1'b0, 40);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_word", 64'(sif.word_o), 64'd0);
        chk("rst_valid", 64'(sif.word_valid_o), 64'd0);
        chk("rst_idx", 64'(sif.word_idx_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_ov("rst_ov", 1'b0);
        step();
        rst_ni = 1'b1; sif.word_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", 64'(sif.word_valid_o), 64'd0);
            chk("post_rst_done", 64'(done), 64'd0);
        end
        run_xfer(rand_vec(), rand_vec(), 100, -1, 1'b0, -1);

        // Load in DONE is dropped; load two edges after last handshake is taken.
        run_xfer(rand_vec(), rand_vec(), 100, -1, 1'b1, -1);
        run_xfer(rand_vec(), rand_vec(), 100, -1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
